// File: rtl/counting_tx_if.sv
// Request/symbol bundle for counting_tx.
// The master side is the control source; the slave side is the transmitter.
interface counting_tx_if #(
    parameter int PAYLOAD_SYMS = 8,
    parameter int LEN_W        = 4
);
    logic                      start;
    logic [2*PAYLOAD_SYMS-1:0] data;
    logic [LEN_W-1:0]          len;
    logic                      ready;
    logic [1:0]                num;
    logic                      num_valid;
    logic                      done;

    modport master (output start, data, len, input ready, num, num_valid, done);
    modport slave  (input start, data, len, output ready, num, num_valid, done);
endinterface

// File: rtl/counting_tx.sv
// counting_tx: serialises one frame per request onto a 2-bit symbol bus.
// Frame = lock preamble 01,10,11, then up to PAYLOAD_SYMS payload symbols
// (LSB first), then GAP_CYCLES idle cycles. All outputs are registered, so
// the state register names what is on the bus during the current cycle.
module counting_tx #(
    parameter int PAYLOAD_SYMS = 8,
    parameter int LEN_W        = 4,
    parameter int GAP_CYCLES   = 2
) (
    input  logic          clk,
    input  logic          reset,
    counting_tx_if.slave  bus
);
    localparam int DW   = 2 * PAYLOAD_SYMS;
    // Phase counter covers preamble index 0..2 and gap count 1..GAP_CYCLES.
    localparam int PH_W = $clog2(GAP_CYCLES + 3);

    typedef enum logic [1:0] {IDLE, PRE, PAY, GAP} state_t;

    state_t            state_q, state_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [DW-1:0]     sh_q, sh_d;
    logic [1:0]        num_q, num_d;
    logic              num_valid_q, num_valid_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic              go_gap;

    // Next-state and next-output logic; outputs are precomputed for the next cycle.
    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        rem_d       = rem_q;
        sh_d        = sh_q;
        num_d       = 2'b00;
        num_valid_d = 1'b0;
        done_d      = 1'b0;
        ready_d     = 1'b0;
        go_gap      = 1'b0;

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (bus.start) begin
                    state_d     = PRE;
                    ph_d        = '0;
                    sh_d        = bus.data;
                    // Oversized lengths clamp to the shift register depth.
                    rem_d       = (bus.len > LEN_W'(PAYLOAD_SYMS)) ? LEN_W'(PAYLOAD_SYMS) : bus.len;
                    num_d       = 2'b01;
                    num_valid_d = 1'b1;
                    ready_d     = 1'b0;
                end
            end
            PRE: begin
                if (ph_q == PH_W'(0)) begin
                    ph_d        = PH_W'(1);
                    num_d       = 2'b10;
                    num_valid_d = 1'b1;
                end else if (ph_q == PH_W'(1)) begin
                    ph_d        = PH_W'(2);
                    num_d       = 2'b11;
                    num_valid_d = 1'b1;
                end else if (rem_q != '0) begin
                    state_d     = PAY;
                    num_d       = sh_q[1:0];
                    num_valid_d = 1'b1;
                    sh_d        = sh_q >> 2;
                    rem_d       = rem_q - LEN_W'(1);
                end else begin
                    go_gap = 1'b1;
                end
            end
            PAY: begin
                // rem_q counts payload symbols still to be launched after the current one.
                if (rem_q != '0) begin
                    num_d       = sh_q[1:0];
                    num_valid_d = 1'b1;
                    sh_d        = sh_q >> 2;
                    rem_d       = rem_q - LEN_W'(1);
                end else begin
                    go_gap = 1'b1;
                end
            end
            GAP: begin
                if (ph_q >= PH_W'(GAP_CYCLES)) begin
                    state_d = IDLE;
                    ph_d    = '0;
                    ready_d = 1'b1;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase

        // Entering the gap: ph counts gap cycles shown so far, done marks the first one.
        if (go_gap) begin
            state_d = GAP;
            ph_d    = PH_W'(1);
            done_d  = 1'b1;
        end
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ph_q        <= '0;
            rem_q       <= '0;
            sh_q        <= '0;
            num_q       <= 2'b00;
            num_valid_q <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            rem_q       <= rem_d;
            sh_q        <= sh_d;
            num_q       <= num_d;
            num_valid_q <= num_valid_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
        end
    end

    assign bus.num       = num_q;
    assign bus.num_valid = num_valid_q;
    assign bus.done      = done_q;
    assign bus.ready     = ready_q;
endmodule

// File: tb/tb_counting_tx.sv
// Self-checking bench for counting_tx: symbol scoreboard plus a lock-detector model.
module tb_counting_tx;
    localparam int PS = 8;
    localparam int LW = 4;
    localparam int GC = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    counting_tx_if #(.PAYLOAD_SYMS(PS), .LEN_W(LW)) bus ();
    counting_tx #(.PAYLOAD_SYMS(PS), .LEN_W(LW), .GAP_CYCLES(GC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0] sym;
        int         idx;
    } exp_t;

    exp_t sb[$];
    int   checks     = 0;
    int   failures   = 0;
    int   done_cnt   = 0;
    int   frames_exp = 0;
    bit   mon_en     = 1'b0;
    bit   first_pre  = 1'b0;
    int   det_st     = 0;
    bit   locked     = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference sticky detector: 01,10,11 locks; 00 leaves state unchanged.
    task automatic det_step(input logic [1:0] s);
        if (s != 2'b00 && !locked) begin
            case (det_st)
                1:       det_st = (s == 2'b10) ? 2 : ((s == 2'b01) ? 1 : 0);
                2: begin
                    if (s == 2'b11) locked = 1'b1;
                    else det_st = (s == 2'b01) ? 1 : 0;
                end
                default: det_st = (s == 2'b01) ? 1 : 0;
            endcase
        end
    endtask

    // Monitor: pop expected symbols whenever num_valid is high.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (bus.num_valid === 1'b1) begin
                chk("sym_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("num", 32'(bus.num), 32'(e.sym));
                    det_step(bus.num);
                    if (e.idx == 2) begin
                        chk("lock_after_pre", 32'(locked), 32'd1);
                        first_pre = 1'b1;
                    end else if (e.idx < 2 && !first_pre) begin
                        chk("no_early_lock", 32'(locked), 32'd0);
                    end
                end
            end else begin
                chk("idle_num", 32'(bus.num), 32'd0);
            end
            if (bus.done === 1'b1) begin
                done_cnt++;
                chk("done_after_frame", 32'(sb.size()), 32'd0);
            end
        end
    end

    task automatic push_frame(input logic [15:0] d, input logic [3:0] l);
        int eff;
        exp_t e;
        eff = (int'(l) > PS) ? PS : int'(l);
        for (int k = 0; k < 3; k++) begin
            e.sym = 2'(k + 1);
            e.idx = k;
            sb.push_back(e);
        end
        for (int k = 0; k < eff; k++) begin
            e.sym = d[2*k +: 2];
            e.idx = 3 + k;
            sb.push_back(e);
        end
    endtask

    // One frame: wait for ready, request, optionally poke start mid-frame, check timing.
    task automatic send(input logic [15:0] d, input logic [3:0] l, input int poke_at);
        int w, n, eff, dc;
        eff = (int'(l) > PS) ? PS : int'(l);
        w = 0;
        while (bus.ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("ready_wait", 32'(bus.ready), 32'd1);
        dc = done_cnt;
        bus.start = 1'b1;
        bus.data  = d;
        bus.len   = l;
        push_frame(d, l);
        frames_exp++;
        @(negedge clk);
        bus.start = 1'b0;
        bus.data  = 16'($urandom);
        bus.len   = 4'($urandom);
        chk("ready_low", 32'(bus.ready), 32'd0);
        n = 1;
        while (bus.done !== 1'b1 && n < 40) begin
            bus.start = (n == poke_at);
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        chk("done_cycle", 32'(n), 32'(4 + eff));
        while (bus.ready !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("ready_cycle", 32'(n), 32'(4 + eff + GC));
        chk("one_done", 32'(done_cnt - dc), 32'd1);
    endtask

    initial begin
        int dc;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.data  = '0;
        bus.len   = '0;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 5; i++) begin
            chk("rst_ready", 32'(bus.ready), 32'd1);
            chk("rst_nv", 32'(bus.num_valid), 32'd0);
            chk("rst_num", 32'(bus.num), 32'd0);
            chk("rst_done", 32'(bus.done), 32'd0);
            @(negedge clk);
        end

        send(16'h00E4, 4'd4, 0);     // 01,10,11,00,01,10,11
        send(16'hABCD, 4'd0, 0);     // preamble only
        send(16'hFFFF, 4'd12, 0);    // clamped to 8 payload symbols
        send(16'h1B6C, 4'd8, 6);     // start poked during payload, ignored
        send(16'h0000, 4'd3, 0);     // payload zeros still carry num_valid
        send(16'h3C5A, 4'd5, 0);     // back-to-back: accepted on first idle cycle

        // Reset in the second payload cycle abandons the frame.
        bus.start = 1'b1;
        bus.data  = 16'h00E4;
        bus.len   = 4'd4;
        push_frame(16'h00E4, 4'd4);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_pay_valid", 32'(bus.num_valid), 32'd1);
        dc    = done_cnt;
        reset = 1'b1;
        @(posedge clk);
        #1 sb.delete();
        @(negedge clk);
        reset = 1'b0;
        chk("mrst_num", 32'(bus.num), 32'd0);
        chk("mrst_nv", 32'(bus.num_valid), 32'd0);
        chk("mrst_ready", 32'(bus.ready), 32'd1);
        chk("mrst_done", 32'(bus.done), 32'd0);
        repeat (4) @(negedge clk);
        chk("mrst_no_done", 32'(done_cnt - dc), 32'd0);

        // start together with reset: reset wins.
        reset     = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        chk("rs_ready", 32'(bus.ready), 32'd1);
        chk("rs_nv", 32'(bus.num_valid), 32'd0);
        @(negedge clk);
        chk("rs_idle_nv", 32'(bus.num_valid), 32'd0);

        send(16'h00E4, 4'd4, 0);     // fresh frame after reset

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("total_done", 32'(done_cnt), 32'(frames_exp));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
